ram_write_arbiter: RTL and testbench
====================================

# ram_write_arbiter

Shares one RAM write port between up to NREQ decompressor output streams: A, B, U/T and control words. Each requester gets a one-word holding buffer and an auto-incrementing address pointer loaded from a per-stream base address. A round-robin arbiter drains one buffered word per cycle into the RAM write port. It sits between the decompressors and each RAM instance, one arbiter per RAM.

## Interface
- N, 32, data word width
- AW, 20, RAM address width
- NREQ, 4, number of requesters
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- store  in  NREQ  per-requester one-cycle strobe: wdata word valid
- wdata  in  NREQ*N  requester i word at [i*N +: N]
- base_addr  in  NREQ*AW  requester i base at [i*AW +: AW]
- load  in  NREQ  reload pointer i from base_addr i (new matrix/vector)
- write  out  1  RAM write enable, registered
- addr  out  AW  RAM write address, registered
- mem_data  out  N  RAM write data, registered
- grant  out  NREQ  one-hot, requester whose word is on the port this cycle, registered
- busy  out  NREQ  pend[i]; buffer i occupied
- ovf  out  NREQ  sticky overflow flags (see Configuration)

## Operation
- Per requester: buf[i] (N bits), pend[i], ptr[i] (AW bits).
- Capture: store[i]=1 and (pend[i]=0, or i is granted this cycle) loads buf[i] <= wdata i and sets pend[i]. Same-cycle drain and refill loses no word.
- Overflow: store[i]=1, pend[i]=1, i not granted. The new word is dropped and buf[i] keeps the old word.
- Arbitration is combinational over pend. The search starts at rr_ptr and wraps modulo NREQ; the first pending index wins. No pend means no grant.
- On grant to i at an edge:
  - write <= 1, addr <= ptr[i], mem_data <= buf[i], grant <= onehot(i)
  - pend[i] cleared unless refilled
  - ptr[i] <= ptr[i]+1, wrapping 2^AW-1 -> 0
  - rr_ptr <= (i+1) mod NREQ
- No grant: write <= 0, grant <= 0. addr and mem_data hold their last values.
- load[i] sets ptr[i] <= base_addr i and overrides the increment. If i is granted in the same cycle, the write uses the old ptr[i], then ptr[i] = base.
- load never affects pend or buf.

## Timing
- Reset values: write=0, addr=0, mem_data=0, grant=0, busy=0, ovf=0. Internal: ptr=0, pend=0, rr_ptr=0.
- Reset mid-operation discards all pending words. The first possible write is 2 edges after reset deasserts.
- Latency: store sampled at edge E0 sets pend at E0. The uncontested write is visible on outputs after edge E1, i.e. 2 cycles from store assertion.
- Throughput: 1 word/cycle total. A single stream sustains 1 word/cycle. With k streams contending, each gets at least 1 grant per k cycles.
- Worst-case wait for a pending word: NREQ-1 cycles.

## Configuration
- WR_ARB_OVF_DETECT_EN defined:
  - ovf[i] is set on every overflow event and cleared only by reset.
  - Dropped words are also counted in an internal 16-bit saturating counter per requester. The counters are not exported and exist for simulation visibility only.
- WR_ARB_OVF_DETECT_EN undefined:
  - ovf is tied to 0 and no detection logic is built.
  - Drop behaviour is unchanged.

## Structure
- Shared package io_pkg holds:
  - default NREQ
  - requester index constants REQ_A=0, REQ_B=1, REQ_U=2, REQ_CTRL=3
  - default base-address constants: A=5, B=10, U=5, T=0, control=0
- Sub-module rr_arbiter(clk, reset, req[NREQ], advance, gnt_onehot, gnt_idx, gnt_valid) holds rr_ptr plus the combinational pick. The top level holds buffers, pointers and output registers.

## Test plan
- Reset: hold reset 3 cycles while store=1111. Required: all outputs 0 and no write for 2 cycles after release.
- Single stream:
  - Stimulus: load[0] with base 5; then store[0] for 4 consecutive cycles, words 0x11..0x14.
  - Required: write=1 on 4 consecutive cycles, addr 5,6,7,8, mem_data 0x11..0x14, no ovf.
- Contention:
  - Stimulus: one cycle store=1111, words 0xA0..0xA3; bases 5,10,0,0; rr_ptr=0.
  - Required: grants in order 0,1,2,3 on consecutive cycles; addrs 5,10,0,0.
- Overflow:
  - Stimulus: hold requester 1 pending while requester 0 streams every cycle, then store[1] again before grant.
  - Required: second word dropped, ovf[1]=1 (macro on) or 0 (macro off), first word written intact.
- Load/grant collision: store[2] with ptr[2]=7 and load[2] with base 0 in the grant cycle. Required: write at addr 7, next word for requester 2 at addr 0.
- Wrap: AW=4, base 15, two words. Required: addrs 15 then 0.

Source files
------------

// File: rtl/io_pkg.sv
// Shared constants for the RAM write arbiters: requester count, stream indices, default bases.
// Imported by the arbiter top and its round-robin picker.
package io_pkg;

  localparam int NREQ_DEF = 4;

  localparam int REQ_A    = 0;
  localparam int REQ_B    = 1;
  localparam int REQ_U    = 2;
  localparam int REQ_CTRL = 3;

  localparam int BASE_A    = 5;
  localparam int BASE_B    = 10;
  localparam int BASE_U    = 5;
  localparam int BASE_T    = 0;
  localparam int BASE_CTRL = 0;

  // Index width that stays legal for a single requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: combinational search over req starting at rr_ptr, wrapping modulo NREQ.
// rr_ptr moves to one past the winner on each advancing grant.
module rr_arbiter
  import io_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IW   = idx_width(NREQ)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] gnt_onehot,
  output logic [IW-1:0]   gnt_idx,
  output logic            gnt_valid
);

  logic [IW-1:0] rr_ptr_q;
  logic [IW-1:0] rr_ptr_d;
  int            cand;

  // Scan from the farthest offset down so the lowest offset from rr_ptr wins last.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = (int'(rr_ptr_q) + k) % NREQ;
      if (req[IW'(cand)]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IW'(cand);
      end
    end
  end

  assign gnt_onehot = gnt_valid ? (NREQ'(1) << gnt_idx) : '0;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (advance && gnt_valid) begin
      rr_ptr_d = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/ram_write_arbiter.sv
// Shares one RAM write port among NREQ streams via one-word buffers and auto-incrementing pointers.
// Optional sticky overflow flags and drop counters under WR_ARB_OVF_DETECT_EN.
module ram_write_arbiter
  import io_pkg::*;
#(
  parameter int N    = 32,
  parameter int AW   = 20,
  parameter int NREQ = NREQ_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    store,
  input  logic [NREQ*N-1:0]  wdata,
  input  logic [NREQ*AW-1:0] base_addr,
  input  logic [NREQ-1:0]    load,
  output logic               write,
  output logic [AW-1:0]      addr,
  output logic [N-1:0]       mem_data,
  output logic [NREQ-1:0]    grant,
  output logic [NREQ-1:0]    busy,
  output logic [NREQ-1:0]    ovf
);

  localparam int IW = idx_width(NREQ);

  logic [N-1:0]    wbuf_q [NREQ];
  logic [N-1:0]    wbuf_d [NREQ];
  logic [AW-1:0]   ptr_q  [NREQ];
  logic [AW-1:0]   ptr_d  [NREQ];
  logic [NREQ-1:0] pend_q, pend_d;
  logic [NREQ-1:0] take;

  logic            write_q;
  logic [AW-1:0]   addr_q;
  logic [N-1:0]    mem_data_q;
  logic [NREQ-1:0] grant_q;

  logic [NREQ-1:0] gnt_oh;
  logic [IW-1:0]   gnt_idx;
  logic            gnt_vld;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
    .clk        (clk),
    .reset      (reset),
    .req        (pend_q),
    .advance    (1'b1),
    .gnt_onehot (gnt_oh),
    .gnt_idx    (gnt_idx),
    .gnt_valid  (gnt_vld)
  );

  // A granted buffer frees up this cycle, so it can accept a refill on the same edge.
  assign take = store & (~pend_q | gnt_oh);

  always_comb begin
    pend_d = pend_q;
    wbuf_d = wbuf_q;
    ptr_d  = ptr_q;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_oh[i]) begin
        pend_d[i] = 1'b0;
        ptr_d[i]  = ptr_q[i] + 1'b1;
      end
      if (take[i]) begin
        pend_d[i] = 1'b1;
        wbuf_d[i] = wdata[i*N +: N];
      end
      if (load[i]) begin
        ptr_d[i] = base_addr[i*AW +: AW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q     <= '0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      mem_data_q <= '0;
      grant_q    <= '0;
      for (int i = 0; i < NREQ; i++) begin
        wbuf_q[i] <= '0;
        ptr_q[i]  <= '0;
      end
    end else begin
      pend_q  <= pend_d;
      wbuf_q  <= wbuf_d;
      ptr_q   <= ptr_d;
      write_q <= gnt_vld;
      grant_q <= gnt_oh;
      if (gnt_vld) begin
        addr_q     <= ptr_q[gnt_idx];
        mem_data_q <= wbuf_q[gnt_idx];
      end
    end
  end

  assign write    = write_q;
  assign addr     = addr_q;
  assign mem_data = mem_data_q;
  assign grant    = grant_q;
  assign busy     = pend_q;

`ifdef WR_ARB_OVF_DETECT_EN
  logic [NREQ-1:0] ovf_evt;
  logic [NREQ-1:0] ovf_q;
  logic [15:0]     drop_cnt_q [NREQ];

  assign ovf_evt = store & pend_q & ~gnt_oh;

  // Drop counters are visibility-only; they saturate rather than wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= '0;
      for (int i = 0; i < NREQ; i++) drop_cnt_q[i] <= '0;
    end else begin
      ovf_q <= ovf_q | ovf_evt;
      for (int i = 0; i < NREQ; i++) begin
        if (ovf_evt[i] && (drop_cnt_q[i] != 16'hFFFF)) drop_cnt_q[i] <= drop_cnt_q[i] + 16'd1;
      end
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = '0;
`endif

endmodule

// File: tb/tb_ram_write_arbiter.sv
// Bench for ram_write_arbiter (AW=4 so pointer wrap is reachable): directed scenarios plus
// randomized traffic compared cycle by cycle against a behavioural model.
module tb_ram_write_arbiter;

  localparam int N    = 32;
  localparam int AW   = 4;
  localparam int NREQ = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic [NREQ-1:0]    store;
  logic [NREQ*N-1:0]  wdata;
  logic [NREQ*AW-1:0] base_addr;
  logic [NREQ-1:0]    load;
  logic               write;
  logic [AW-1:0]      addr;
  logic [N-1:0]       mem_data;
  logic [NREQ-1:0]    grant;
  logic [NREQ-1:0]    busy;
  logic [NREQ-1:0]    ovf;

  ram_write_arbiter #(.N(N), .AW(AW), .NREQ(NREQ)) dut (
    .clk       (clk),
    .reset     (reset),
    .store     (store),
    .wdata     (wdata),
    .base_addr (base_addr),
    .load      (load),
    .write     (write),
    .addr      (addr),
    .mem_data  (mem_data),
    .grant     (grant),
    .busy      (busy),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Behavioural model: a word is either waiting in its slot or not; each cycle the first
  // waiting slot at or after the turn marker is written, then new words/loads apply.
  logic [N-1:0]    m_word [NREQ];
  int              m_ptr  [NREQ];
  logic [NREQ-1:0] m_wait;
  int              m_turn;
  logic            e_write;
  logic [AW-1:0]   e_addr;
  logic [N-1:0]    e_data;
  logic [NREQ-1:0] e_grant;
  logic [NREQ-1:0] e_ovf;

  task automatic model_step(input logic rst, input logic [3:0] st, input logic [3:0] ld,
                            input logic [127:0] wd, input logic [15:0] bases);
    int w;
    if (rst) begin
      for (int i = 0; i < NREQ; i++) begin m_word[i] = '0; m_ptr[i] = 0; end
      m_wait = '0; m_turn = 0;
      e_write = 0; e_addr = '0; e_data = '0; e_grant = '0; e_ovf = '0;
      return;
    end
    w = -1;
    for (int k = 0; k < NREQ; k++)
      if (w < 0 && m_wait[(m_turn + k) % NREQ]) w = (m_turn + k) % NREQ;
    if (w >= 0) begin
      e_write   = 1'b1;
      e_addr    = AW'(m_ptr[w]);
      e_data    = m_word[w];
      e_grant   = NREQ'(1) << w;
      m_wait[w] = 1'b0;
      m_ptr[w]  = (m_ptr[w] + 1) % (1 << AW);
      m_turn    = (w + 1) % NREQ;
    end else begin
      e_write = 1'b0;
      e_grant = '0;
    end
    for (int i = 0; i < NREQ; i++) begin
      if (st[i]) begin
        if (m_wait[i]) begin
`ifdef WR_ARB_OVF_DETECT_EN
          e_ovf[i] = 1'b1;
`endif
        end else begin
          m_word[i] = wd[i*N +: N];
          m_wait[i] = 1'b1;
        end
      end
      if (ld[i]) m_ptr[i] = int'(bases[i*AW +: AW]);
    end
  endtask

  int            obs_cyc   [$];
  logic [AW-1:0] obs_addr  [$];
  logic [N-1:0]  obs_data  [$];
  logic [3:0]    obs_grant [$];

  task automatic clear_obs();
    obs_cyc.delete(); obs_addr.delete(); obs_data.delete(); obs_grant.delete();
  endtask

  task automatic cycle(input logic rst, input logic [3:0] st, input logic [3:0] ld,
                       input logic [127:0] wd);
    reset = rst; store = st; load = ld; wdata = wd;
    @(posedge clk);
    model_step(rst, st, ld, wd, base_addr);
    #1;
    chk("write", 64'(write), 64'(e_write));
    chk("grant", 64'(grant), 64'(e_grant));
    chk("addr", 64'(addr), 64'(e_addr));
    chk("mem_data", 64'(mem_data), 64'(e_data));
    chk("busy", 64'(busy), 64'(m_wait));
    chk("ovf", 64'(ovf), 64'(e_ovf));
    if (write === 1'b1) begin
      obs_cyc.push_back(cyc); obs_addr.push_back(addr);
      obs_data.push_back(mem_data); obs_grant.push_back(grant);
    end
    cyc++;
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 4'hF, 4'h0, '0);
  endtask

  logic [127:0] wv;
  logic [3:0]   rs, rl;
  int           ovf_exp;

  initial begin
    reset = 1'b1; store = '0; load = '0; wdata = '0; base_addr = '0;

    // Reset held with all strobes active, then released.
    do_reset();
    chk("rst_write", 64'(write), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    cycle(1'b0, 4'hF, 4'h0, {32'h4, 32'h3, 32'h2, 32'h1});
    chk("rel_e1_nowrite", 64'(write), 64'd0);
    cycle(1'b0, 4'h0, 4'h0, '0);
    chk("rel_e2_write", 64'(write), 64'd1);

    // Single stream from base 5.
    do_reset();
    base_addr = {4'd0, 4'd0, 4'd10, 4'd5};
    cycle(1'b0, 4'h0, 4'h1, '0);
    clear_obs();
    for (int k = 0; k < 4; k++) cycle(1'b0, 4'h1, 4'h0, 128'(32'h11 + k));
    for (int k = 0; k < 3; k++) cycle(1'b0, 4'h0, 4'h0, '0);
    chk("ss_count", 64'(obs_cyc.size()), 64'd4);
    for (int k = 0; k < 4 && k < obs_cyc.size(); k++) begin
      chk("ss_addr", 64'(obs_addr[k]), 64'(5 + k));
      chk("ss_data", 64'(obs_data[k]), 64'(32'h11 + k));
      chk("ss_consec", 64'(obs_cyc[k] - obs_cyc[0]), 64'(k));
    end
    chk("ss_ovf", 64'(ovf), 64'd0);

    // Four-way contention in one cycle.
    do_reset();
    base_addr = {4'd0, 4'd0, 4'd10, 4'd5};
    cycle(1'b0, 4'h0, 4'hF, '0);
    clear_obs();
    cycle(1'b0, 4'hF, 4'h0, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
    for (int k = 0; k < 6; k++) cycle(1'b0, 4'h0, 4'h0, '0);
    chk("ct_count", 64'(obs_cyc.size()), 64'd4);
    for (int k = 0; k < 4 && k < obs_cyc.size(); k++) begin
      chk("ct_grant", 64'(obs_grant[k]), 64'(4'(1) << k));
      chk("ct_data", 64'(obs_data[k]), 64'(32'hA0 + k));
      chk("ct_consec", 64'(obs_cyc[k] - obs_cyc[0]), 64'(k));
    end
    if (obs_cyc.size() == 4) begin
      chk("ct_addr0", 64'(obs_addr[0]), 64'd5);
      chk("ct_addr1", 64'(obs_addr[1]), 64'd10);
      chk("ct_addr2", 64'(obs_addr[2]), 64'd0);
      chk("ct_addr3", 64'(obs_addr[3]), 64'd0);
    end

    // Overflow: requester 1 re-strobes while requester 0 holds the grant.
    do_reset();
    base_addr = {4'd0, 4'd0, 4'd10, 4'd5};
    cycle(1'b0, 4'h0, 4'h3, '0);
    clear_obs();
    cycle(1'b0, 4'h3, 4'h0, {64'h0, 32'hB1, 32'hB0});
    cycle(1'b0, 4'h3, 4'h0, {64'h0, 32'hBF, 32'hB2});
    for (int k = 0; k < 4; k++) cycle(1'b0, 4'h0, 4'h0, '0);
`ifdef WR_ARB_OVF_DETECT_EN
    ovf_exp = 1;
`else
    ovf_exp = 0;
`endif
    chk("of_ovf1", 64'(ovf[1]), 64'(ovf_exp));
    chk("of_count", 64'(obs_cyc.size()), 64'd3);
    if (obs_cyc.size() == 3) begin
      chk("of_w0", 64'(obs_data[0]), 64'hB0);
      chk("of_w1_data", 64'(obs_data[1]), 64'hB1);
      chk("of_w1_addr", 64'(obs_addr[1]), 64'd10);
      chk("of_w2", 64'(obs_data[2]), 64'hB2);
    end

    // Load colliding with grant on requester 2.
    do_reset();
    base_addr = {4'd0, 4'd7, 4'd0, 4'd0};
    cycle(1'b0, 4'h0, 4'h4, '0);
    clear_obs();
    cycle(1'b0, 4'h4, 4'h0, {32'h0, 32'hC0, 64'h0});
    base_addr = {4'd0, 4'd0, 4'd0, 4'd0};
    cycle(1'b0, 4'h4, 4'h4, {32'h0, 32'hC1, 64'h0});
    for (int k = 0; k < 3; k++) cycle(1'b0, 4'h0, 4'h0, '0);
    chk("lc_count", 64'(obs_cyc.size()), 64'd2);
    if (obs_cyc.size() == 2) begin
      chk("lc_addr0", 64'(obs_addr[0]), 64'd7);
      chk("lc_addr1", 64'(obs_addr[1]), 64'd0);
      chk("lc_data1", 64'(obs_data[1]), 64'hC1);
    end

    // Pointer wrap at 2^AW-1.
    do_reset();
    base_addr = {4'd15, 4'd0, 4'd0, 4'd0};
    cycle(1'b0, 4'h0, 4'h8, '0);
    clear_obs();
    cycle(1'b0, 4'h8, 4'h0, {32'hD0, 96'h0});
    cycle(1'b0, 4'h8, 4'h0, {32'hD1, 96'h0});
    for (int k = 0; k < 3; k++) cycle(1'b0, 4'h0, 4'h0, '0);
    chk("wr_count", 64'(obs_cyc.size()), 64'd2);
    if (obs_cyc.size() == 2) begin
      chk("wr_addr0", 64'(obs_addr[0]), 64'd15);
      chk("wr_addr1", 64'(obs_addr[1]), 64'd0);
    end

    // Randomized traffic with occasional loads and resets.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NREQ; i++) wv[i*N +: N] = $urandom;
      rs = 4'($urandom);
      rl = '0;
      for (int i = 0; i < NREQ; i++) if ($urandom_range(7) == 0) rl[i] = 1'b1;
      base_addr = 16'($urandom);
      cycle(($urandom_range(199) == 0), rs, rl, wv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
